// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage and its control-side users.
package fetch_pkg;

  localparam logic [1:0] PCSRC_NEXT   = 2'd0;
  localparam logic [1:0] PCSRC_BRANCH = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_STALL  = 2'd3;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    StFetch,
    StWait,
    StExec,
    StFault
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory req/gnt/rvalid bus between the fetch stage and memory.
interface fetch_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req;
  logic [DATA_WIDTH-1:0] addr;
  logic                  gnt;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/next_pc_sel.sv
// Next-PC selection from the control PCSrc code, with target alignment check.
module next_pc_sel
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [1:0]            pc_src,
  input  logic [DATA_WIDTH-1:0] imm_ext,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic [DATA_WIDTH-1:0] next_pc,
  output logic                  hold,
  output logic                  misaligned
);

  always_comb begin
    next_pc    = pc + DATA_WIDTH'(4);
    hold       = 1'b0;
    misaligned = 1'b0;
    unique case (pc_src)
      PCSRC_NEXT: begin
        next_pc = pc + DATA_WIDTH'(4);
      end
      PCSRC_BRANCH: begin
        next_pc    = pc + imm_ext;
        misaligned = (next_pc[1:0] != 2'b00);
      end
      PCSRC_JUMP: begin
        // jalr clears bit 0 before the alignment test
        next_pc    = {alu_result[DATA_WIDTH-1:1], 1'b0};
        misaligned = next_pc[1];
      end
      PCSRC_STALL: begin
        next_pc = pc;
        hold    = 1'b1;
      end
      default: begin
        next_pc = pc;
      end
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, runs FETCH/WAIT/EXEC/FAULT over the imem bus and
// presents one instruction per fetch to decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned          DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC  = 32'hBFC00000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fetch_unit_if.master          imem,
  input  logic [1:0]            PCSrc,
  input  logic [DATA_WIDTH-1:0] ImmExt,
  input  logic [DATA_WIDTH-1:0] ALUResult,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] pc_plus4,
  output logic                  fault
);

  fetch_state_t          state_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic                  fault_q;

  logic [DATA_WIDTH-1:0] next_pc;
  logic                  hold;
  logic                  misaligned;

  next_pc_sel #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_next_pc_sel (
    .pc        (pc_q),
    .pc_src    (PCSrc),
    .imm_ext   (ImmExt),
    .alu_result(ALUResult),
    .next_pc   (next_pc),
    .hold      (hold),
    .misaligned(misaligned)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      instr_q <= DATA_WIDTH'(NOP_INSTR);
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        StFetch: begin
          if (imem.gnt) state_q <= StWait;
        end
        StWait: begin
          if (imem.rvalid) begin
            instr_q <= imem.rdata;
            state_q <= StExec;
          end
        end
        StExec: begin
          if (hold) begin
            state_q <= StExec;
          end else if (misaligned) begin
            // keep the PC of the offending instruction for debug
            state_q <= StFault;
            fault_q <= 1'b1;
          end else begin
            pc_q    <= next_pc;
            state_q <= StFetch;
          end
        end
        StFault: begin
          state_q <= StFault;
        end
        default: begin
          state_q <= StFault;
        end
      endcase
    end
  end

  // Outputs depend only on registered state, never on imem inputs.
  assign imem.req    = (state_q == StFetch);
  assign imem.addr   = pc_q;
  assign instr_valid = (state_q == StExec);
  assign instr       = instr_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + DATA_WIDTH'(4);
  assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: bench-driven memory with random latency
// and a PC/instruction reference model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hBFC00000;
  localparam logic [31:0] NOP    = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  PCSrc;
  logic [31:0] ImmExt;
  logic [31:0] ALUResult;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fault;

  fetch_unit_if #(.DATA_WIDTH(32)) imem ();

  fetch_unit #(
    .DATA_WIDTH(32),
    .RESET_PC  (RST_PC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem       (imem),
    .PCSrc      (PCSrc),
    .ImmExt     (ImmExt),
    .ALUResult  (ALUResult),
    .instr      (instr),
    .instr_valid(instr_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] pc_m;
  logic [31:0] instr_m;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    checks++;
    if (imem.req !== 1'b1 || imem.addr !== RST_PC || pc !== RST_PC) begin
      errors++;
      $display("FAIL %s_fetch req=%b addr=%h pc=%h expected req=1 addr=%h", tag, imem.req,
               imem.addr, pc, RST_PC);
    end
    checks++;
    if (instr_valid !== 1'b0 || fault !== 1'b0 || instr !== NOP) begin
      errors++;
      $display("FAIL %s_outputs valid=%b fault=%b instr=%h expected 0 0 %h", tag, instr_valid,
               fault, instr, NOP);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    pc_m    = RST_PC;
    instr_m = NOP;
  endtask

  // Starts in FETCH; ends one cycle into EXEC.
  task automatic do_fetch(input int gnt_dly, input int rv_dly, input logic [31:0] data);
    checks++;
    if (imem.req !== 1'b1 || imem.addr !== pc_m || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_issue req=%b addr=%h valid=%b expected 1 %h 0", imem.req, imem.addr,
               instr_valid, pc_m);
    end
    for (int i = 0; i < gnt_dly; i++) begin
      imem.gnt    = 1'b0;
      imem.rvalid = 1'($urandom % 2);
      imem.rdata  = $urandom;
      step();
      checks++;
      if (imem.req !== 1'b1 || imem.addr !== pc_m) begin
        errors++;
        $display("FAIL fetch_hold req=%b addr=%h expected 1 %h", imem.req, imem.addr, pc_m);
      end
    end
    imem.gnt    = 1'b1;
    imem.rvalid = 1'b1;
    imem.rdata  = $urandom;
    step();
    imem.gnt    = 1'b0;
    imem.rvalid = 1'b0;
    for (int i = 0; i <= rv_dly; i++) begin
      checks++;
      if (imem.req !== 1'b0 || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL wait_state req=%b valid=%b expected 0 0", imem.req, instr_valid);
      end
      if (i < rv_dly) step();
    end
    imem.rvalid = 1'b1;
    imem.rdata  = data;
    instr_m     = data;
    step();
    imem.rvalid = 1'b0;
    imem.rdata  = $urandom;
    checks++;
    if (instr_valid !== 1'b1 || instr !== instr_m || pc !== pc_m || pc_plus4 !== pc_m + 4) begin
      errors++;
      $display("FAIL exec_present valid=%b instr=%h pc=%h pc4=%h expected 1 %h %h %h",
               instr_valid, instr, pc, pc_plus4, instr_m, pc_m, pc_m + 4);
    end
  endtask

  // Starts one cycle into EXEC; stalls, then applies src.
  task automatic do_exec(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] alu,
                         input int stalls);
    logic [31:0] target;
    logic        bad;
    for (int i = 0; i < stalls; i++) begin
      PCSrc     = 2'd3;
      ImmExt    = $urandom;
      ALUResult = $urandom;
      step();
      checks++;
      if (instr_valid !== 1'b1 || instr !== instr_m || pc !== pc_m || imem.req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold valid=%b instr=%h pc=%h req=%b expected 1 %h %h 0",
                 instr_valid, instr, pc, imem.req, instr_m, pc_m);
      end
    end
    PCSrc     = src;
    ImmExt    = imm;
    ALUResult = alu;
    step();
    PCSrc     = 2'($urandom);
    ImmExt    = $urandom;
    ALUResult = $urandom;
    case (src)
      2'd1:    target = pc_m + imm;
      2'd2:    target = alu - (alu % 2);
      default: target = pc_m + 4;
    endcase
    bad = (src != 2'd0) && ((target % 4) != 0);
    if (bad) begin
      checks++;
      if (fault !== 1'b1 || imem.req !== 1'b0 || instr_valid !== 1'b0 || pc !== pc_m) begin
        errors++;
        $display("FAIL fault_entry fault=%b req=%b valid=%b pc=%h expected 1 0 0 %h", fault,
                 imem.req, instr_valid, pc, pc_m);
      end
    end else begin
      pc_m = target;
      checks++;
      if (fault !== 1'b0 || imem.req !== 1'b1 || imem.addr !== pc_m || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL next_fetch fault=%b req=%b addr=%h valid=%b expected 0 1 %h 0", fault,
                 imem.req, imem.addr, instr_valid, pc_m);
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    check_reset_state("reset");
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 4; k++) begin
      do_fetch(0, 0, NOP);
      do_exec(2'd0, 32'h0, 32'h0, 0);
    end
    checks++;
    if (imem.addr !== 32'hBFC00010) begin
      errors++;
      $display("FAIL seq_addr addr=%h expected bfc00010", imem.addr);
    end
  endtask

  task automatic test_branch_jalr();
    do_fetch(0, 0, $urandom);
    do_exec(2'd1, 32'hFFFFFFF0, 32'h0, 0);
    checks++;
    if (imem.addr !== 32'hBFC00000) begin
      errors++;
      $display("FAIL branch_back addr=%h expected bfc00000", imem.addr);
    end
    do_fetch(0, 0, $urandom);
    do_exec(2'd2, 32'h0, 32'h00000105, 0);
    checks++;
    if (imem.addr !== 32'h00000104) begin
      errors++;
      $display("FAIL jalr_clear addr=%h expected 00000104", imem.addr);
    end
  endtask

  task automatic test_delay();
    do_fetch(2, 3, 32'hA5A5_0F0F);
    do_exec(2'd0, 32'h0, 32'h0, 0);
  endtask

  task automatic test_stall();
    do_fetch(0, 0, 32'h1234_5678);
    do_exec(2'd0, 32'h0, 32'h0, 5);
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      do_fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom);
      do_exec(2'($urandom_range(0, 2)), $urandom & 32'hFFFF_FFFC,
              ($urandom & 32'hFFFF_FFFC) | 32'($urandom % 2), int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_wrap();
    do_fetch(0, 0, $urandom);
    do_exec(2'd2, 32'h0, 32'hFFFF_FFFC, 0);
    do_fetch(1, 1, $urandom);
    do_exec(2'd0, 32'h0, 32'h0, 0);
    checks++;
    if (imem.addr !== 32'h0) begin
      errors++;
      $display("FAIL pc_wrap addr=%h expected 00000000", imem.addr);
    end
  endtask

  task automatic test_fault();
    do_fetch(0, 0, $urandom);
    do_exec(2'd1, 32'h0000_0006, 32'h0, 0);
    for (int i = 0; i < 10; i++) begin
      imem.gnt    = 1'($urandom % 2);
      imem.rvalid = 1'($urandom % 2);
      step();
      checks++;
      if (fault !== 1'b1 || imem.req !== 1'b0 || instr_valid !== 1'b0 || pc !== pc_m) begin
        errors++;
        $display("FAIL fault_sticky fault=%b req=%b valid=%b pc=%h expected 1 0 0 %h", fault,
                 imem.req, instr_valid, pc, pc_m);
      end
    end
    imem.gnt    = 1'b0;
    imem.rvalid = 1'b0;
    apply_reset();
    check_reset_state("fault_clear");
  endtask

  task automatic test_reset_in_wait();
    do_fetch(0, 0, $urandom);
    do_exec(2'd0, 32'h0, 32'h0, 0);
    imem.gnt = 1'b1;
    step();
    imem.gnt = 1'b0;
    apply_reset();
    check_reset_state("wait_reset");
  endtask

  initial begin
    rst_n       = 1'b0;
    PCSrc       = 2'd0;
    ImmExt      = 32'h0;
    ALUResult   = 32'h0;
    imem.gnt    = 1'b0;
    imem.rvalid = 1'b0;
    imem.rdata  = 32'h0;
    pc_m        = RST_PC;
    instr_m     = NOP;
    step();
    test_reset();
    test_sequential();
    test_branch_jalr();
    test_delay();
    test_stall();
    test_random();
    test_wrap();
    test_fault();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
